reg_cmd_sequencer: RTL

REG_CMD_SEQUENCER -- requirements
Module: reg_cmd_sequencer

---
 rtl/reg_cmd_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/reg_cmd_sequencer.sv
// Command sequencer that drives an external n-bit register (clear/load/inc/dec)
// through its E/FunSel/I controls, repeating inc/dec and stopping at the register limits.
module reg_cmd_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [N-1:0] cmd_data,
    input  logic [3:0]   cmd_count,
    input  logic [N-1:0] q,
    output logic         e,
    output logic [1:0]   funsel,
    output logic [N-1:0] i,
    output logic         busy,
    output logic         done,
    output logic         sat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_INC  = 2'b11;

    state_t       state_q, state_d;
    logic [1:0]   op_q;
    logic [N-1:0] data_q;
    logic [3:0]   cnt_q;
    logic         sat_q;
    logic         accept;
    logic         at_limit;

    assign accept = (state_q == IDLE) && cmd_valid;

    // Another step would wrap the register, so the command ends without issuing it.
    assign at_limit = ((op_q == OP_DEC) && (q == '0)) ||
                      ((op_q == OP_INC) && (q == '1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_CLR;
            data_q <= '0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            cnt_q  <= (cmd_count == 4'd0) ? 4'd1 : cmd_count;
            sat_q  <= 1'b0;
        end else if (state_q == EXEC) begin
            if (at_limit) begin
                sat_q <= 1'b1;
            end else if ((op_q == OP_DEC) || (op_q == OP_INC)) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // NOTE: each combinational block assigns a default before the case so no
    // path leaves an output unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_valid) state_d = EXEC;
            EXEC: begin
                if (at_limit || (op_q == OP_CLR) || (op_q == OP_LOAD) || (cnt_q == 4'd1)) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        e         = 1'b0;
        funsel    = OP_CLR;
        i         = '0;
        done      = 1'b0;
        sat       = 1'b0;
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        case (state_q)
            EXEC: begin
                e      = !at_limit;
                funsel = op_q;
                i      = data_q;
            end
            FIN: begin
                done = 1'b1;
                sat  = sat_q;
            end
            default: ;
        endcase
    end

endmodule
